mcs4_bus_tracer: RTL and testbench

- Passive monitor on the shared MCS-4 4-bit bus, downstream of the i4004/i4001/i4002 cluster.
- Tracks the 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from sync and clken_2.
- Assembles one trace record per instruction cycle: fetch address, instruction byte, X2 data nibble, I/O flag.
- Buffers records in a FIFO drained over a valid/ready interface, for on-board program trace and for bench self-checking.

---
 rtl/mcs4_bus_tracer_if.sv | 33 +++
 rtl/mcs4_bus_tracer.sv | 132 +++++++++++++
 tb/tb_mcs4_bus_tracer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcs4_bus_tracer_if.sv
// rtl/mcs4_bus_tracer_if.sv - MCS-4 bus tap and trace-record stream interface
interface mcs4_bus_tracer_if #(
    parameter int CNT_W = 16
);
    logic             clken_2;
    logic             sync;
    logic             cm_rom;
    logic [3:0]       cm_ram;
    logic [3:0]       dbus_in;
    logic             enable;
    logic             rec_valid;
    logic             rec_ready;
    logic [11:0]      rec_addr;
    logic [7:0]       rec_instr;
    logic [3:0]       rec_x2;
    logic             rec_io;
    logic             locked;
    logic             sync_err;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;

    modport master (
        output clken_2, sync, cm_rom, cm_ram, dbus_in, enable, rec_ready,
        input  rec_valid, rec_addr, rec_instr, rec_x2, rec_io,
        input  locked, sync_err, overflow, drop_count
    );

    modport slave (
        input  clken_2, sync, cm_rom, cm_ram, dbus_in, enable, rec_ready,
        output rec_valid, rec_addr, rec_instr, rec_x2, rec_io,
        output locked, sync_err, overflow, drop_count
    );
endinterface

// File: rtl/mcs4_bus_tracer.sv
// rtl/mcs4_bus_tracer.sv - passive MCS-4 instruction-cycle tracer with record FIFO
module mcs4_bus_tracer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    mcs4_bus_tracer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_phase;
    logic [11:0]      r_addr;
    logic [7:0]       r_instr;
    logic             r_io;
    logic             r_rec_en;
    logic             r_sync_err;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_count;

    logic [24:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic             r_valid;
    logic [24:0]      r_out;

    logic             w_sync_bad;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_write;
    logic             w_drop;
    logic [AW-1:0]    w_rp_next;
    logic [AW:0]      w_avail;
    logic [24:0]      w_rec;

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_UNLOCKED && bus.clken_2 && bus.sync)
            w_state_next = ST_LOCKED;
    end

    always_comb begin
        w_sync_bad = bus.clken_2 && bus.sync && (r_state == ST_LOCKED) && (r_phase != 3'd7);
        // A sync landing on X2 itself is a misalignment, so that record is not pushed.
        w_push     = bus.clken_2 && (r_state == ST_LOCKED) && (r_phase == 3'd6) && r_rec_en && !bus.sync;
        w_pop      = r_valid && bus.rec_ready;
        w_full     = (r_count == (AW+1)'(DEPTH));
        w_write    = w_push && (!w_full || w_pop);
        w_drop     = w_push && w_full && !w_pop;
        w_rp_next  = r_rp + AW'(w_pop);
        // Output stage shows only entries present before this edge, giving one clk push-to-valid.
        w_avail    = r_count - (AW+1)'(w_pop);
        w_rec      = {r_addr, r_instr, bus.dbus_in, r_io};
    end

    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_wp] <= w_rec;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_UNLOCKED;
            r_phase      <= 3'd0;
            r_addr       <= 12'd0;
            r_instr      <= 8'd0;
            r_io         <= 1'b0;
            r_rec_en     <= 1'b0;
            r_sync_err   <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_out        <= '0;
        end else begin
            r_state <= w_state_next;
            if (bus.clken_2) begin
                r_phase <= bus.sync ? 3'd0 : r_phase + 3'd1;
                case (r_phase)
                    3'd0: begin
                        r_addr[3:0] <= bus.dbus_in;
                        r_rec_en    <= bus.enable && (r_state == ST_LOCKED);
                    end
                    3'd1: r_addr[7:4]   <= bus.dbus_in;
                    3'd2: r_addr[11:8]  <= bus.dbus_in;
                    3'd3: r_instr[7:4]  <= bus.dbus_in;
                    3'd4: begin
                        r_instr[3:0] <= bus.dbus_in;
                        r_io         <= bus.cm_rom | (|bus.cm_ram);
                    end
                    default: ;
                endcase
                if (w_sync_bad) begin
                    r_sync_err <= 1'b1;
                    r_rec_en   <= 1'b0;
                end
            end

            if (w_write)
                r_wp <= r_wp + AW'(1);
            r_rp    <= w_rp_next;
            r_count <= r_count + (AW+1)'(w_write) - (AW+1)'(w_pop);
            r_valid <= (w_avail != '0);
            if (w_avail != '0)
                r_out <= r_mem[w_rp_next];

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1)
                    r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign bus.rec_valid  = r_valid;
    assign bus.rec_addr   = r_out[24:13];
    assign bus.rec_instr  = r_out[12:5];
    assign bus.rec_x2     = r_out[4:1];
    assign bus.rec_io     = r_out[0];
    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.sync_err   = r_sync_err;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_mcs4_bus_tracer.sv
// tb/tb_mcs4_bus_tracer.sv - scoreboard bench for mcs4_bus_tracer
module tb_mcs4_bus_tracer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  instr;
        logic [3:0]  x2;
        logic        io;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   exp_drops = 0;
    rec_t q[$];
    rec_t e;

    mcs4_bus_tracer_if #(.CNT_W(CNT_W)) bus ();

    mcs4_bus_tracer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && bus.rec_valid && bus.rec_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_record: got addr=%h instr=%h x2=%h io=%b, required none",
                         bus.rec_addr, bus.rec_instr, bus.rec_x2, bus.rec_io);
            end else begin
                e = q.pop_front();
                if (bus.rec_addr !== e.addr || bus.rec_instr !== e.instr ||
                    bus.rec_x2 !== e.x2 || bus.rec_io !== e.io) begin
                    fails++;
                    $display("FAIL record: got addr=%h instr=%h x2=%h io=%b, required addr=%h instr=%h x2=%h io=%b",
                             bus.rec_addr, bus.rec_instr, bus.rec_x2, bus.rec_io,
                             e.addr, e.instr, e.x2, e.io);
                end
            end
        end
    end

    task automatic sub(input logic [3:0] d, input logic s, input logic rom,
                       input logic [3:0] ram, input bit chk_lat);
        bus.dbus_in = d;
        bus.sync    = s;
        bus.cm_rom  = rom;
        bus.cm_ram  = ram;
        bus.clken_2 = 1'b1;
        @(posedge clk); #1;
        bus.clken_2 = 1'b0;
        bus.sync    = 1'b0;
        bus.cm_rom  = 1'b0;
        bus.cm_ram  = 4'd0;
        if (chk_lat) begin
            tests++;
            if (bus.rec_valid !== 1'b0) begin
                fails++;
                $display("FAIL latency_early: rec_valid=%b right after X2 edge, required 0", bus.rec_valid);
            end
        end
        @(posedge clk); #1;
        if (chk_lat) begin
            tests++;
            if (bus.rec_valid !== 1'b1) begin
                fails++;
                $display("FAIL latency_one: rec_valid=%b one clk after X2 edge, required 1", bus.rec_valid);
            end
        end
    endtask

    task automatic icycle(input logic [11:0] a, input logic [7:0] ins, input logic [3:0] x2,
                          input logic rom, input logic [3:0] ram, input bit en_a1,
                          input bit exp_push, input bit lat);
        rec_t r;
        bus.enable = en_a1;
        sub(a[3:0], 1'b0, 1'b0, 4'd0, 1'b0);
        bus.enable = !en_a1;
        sub(a[7:4], 1'b0, 1'b0, 4'd0, 1'b0);
        sub(a[11:8], 1'b0, 1'b0, 4'd0, 1'b0);
        sub(ins[7:4], 1'b0, 1'b0, 4'd0, 1'b0);
        sub(ins[3:0], 1'b0, rom, ram, 1'b0);
        sub(4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        if (exp_push) begin
            r.addr = a; r.instr = ins; r.x2 = x2; r.io = rom | (|ram);
            if (q.size() < DEPTH) q.push_back(r);
            else exp_drops++;
        end
        sub(x2, 1'b0, 1'b0, 4'd0, lat);
        sub(4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        bus.enable = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0 && !bus.rec_valid) break;
            @(posedge clk); #1;
        end
        tests++;
        if (q.size() != 0 || bus.rec_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain: %0d records outstanding, rec_valid=%b, required 0 and 0",
                     name, q.size(), bus.rec_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.locked !== 1'b0 || bus.rec_valid !== 1'b0 || bus.rec_addr !== 12'd0 ||
            bus.rec_instr !== 8'd0 || bus.rec_x2 !== 4'd0 || bus.rec_io !== 1'b0 ||
            bus.sync_err !== 1'b0 || bus.overflow !== 1'b0 || bus.drop_count !== '0) begin
            fails++;
            $display("FAIL reset_state: locked=%b valid=%b addr=%h instr=%h x2=%h io=%b serr=%b ovf=%b drops=%0d, required all 0",
                     bus.locked, bus.rec_valid, bus.rec_addr, bus.rec_instr, bus.rec_x2,
                     bus.rec_io, bus.sync_err, bus.overflow, bus.drop_count);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) sub(4'(i + 3), 1'b0, 1'b0, 4'd0, 1'b0);
        tests++;
        if (bus.locked !== 1'b0 || bus.rec_valid !== 1'b0) begin
            fails++;
            $display("FAIL prelock: locked=%b rec_valid=%b, required 0 0", bus.locked, bus.rec_valid);
        end
        sub(4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        tests++;
        if (bus.locked !== 1'b1 || bus.sync_err !== 1'b0) begin
            fails++;
            $display("FAIL lock: locked=%b sync_err=%b, required 1 0", bus.locked, bus.sync_err);
        end
        icycle(12'h000, 8'h12, 4'h3, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        drain("reset");
    endtask

    task automatic test_program;
        icycle(12'h000, 8'hD5, 4'($urandom_range(0, 15)), 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        icycle(12'h001, 8'hB2, 4'($urandom_range(0, 15)), 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        icycle(12'h002, 8'h00, 4'($urandom_range(0, 15)), 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        drain("program");
    endtask

    task automatic test_enable;
        icycle(12'h010, 8'h20, 4'h1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        icycle(12'h011, 8'h21, 4'h2, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        drain("enable");
    endtask

    task automatic test_io;
        bus.rec_ready = 1'b0;
        icycle(12'h003, 8'hE0, 4'h7, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0);
        tests++;
        if (bus.rec_valid !== 1'b1 || bus.rec_io !== 1'b1 || bus.rec_instr !== 8'hE0 || bus.rec_x2 !== 4'h7) begin
            fails++;
            $display("FAIL io_record: valid=%b io=%b instr=%h x2=%h, required 1 1 e0 7",
                     bus.rec_valid, bus.rec_io, bus.rec_instr, bus.rec_x2);
        end
        bus.rec_ready = 1'b1;
        drain("io");
    endtask

    task automatic test_sync_err;
        sub(4'hB, 1'b0, 1'b0, 4'd0, 1'b0);
        sub(4'hA, 1'b0, 1'b0, 4'd0, 1'b0);
        sub(4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        sub(4'h4, 1'b1, 1'b0, 4'd0, 1'b0);
        tests++;
        if (bus.sync_err !== 1'b1 || bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL sync_err_set: sync_err=%b locked=%b, required 1 1", bus.sync_err, bus.locked);
        end
        icycle(12'h0AC, 8'h40, 4'h9, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        drain("sync_err");
        tests++;
        if (bus.sync_err !== 1'b1) begin
            fails++;
            $display("FAIL sync_err_sticky: sync_err=%b, required 1", bus.sync_err);
        end
    endtask

    task automatic test_overflow;
        bus.rec_ready = 1'b0;
        exp_drops = 0;
        for (int i = 0; i < 6; i++)
            icycle(12'h100 + 12'(i), 8'h60 + 8'(i), 4'(i), 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        tests++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== CNT_W'(exp_drops)) begin
            fails++;
            $display("FAIL overflow: overflow=%b drop_count=%0d, required 1 %0d",
                     bus.overflow, bus.drop_count, exp_drops);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.rec_valid !== 1'b1 || bus.rec_addr !== 12'h100) begin
                fails++;
                $display("FAIL stall_hold: valid=%b addr=%h, required 1 100", bus.rec_valid, bus.rec_addr);
            end
            @(posedge clk); #1;
        end
        bus.rec_ready = 1'b1;
        drain("overflow");
    endtask

    task automatic test_reset_mid;
        bus.rec_ready = 1'b0;
        icycle(12'h300, 8'h70, 4'h1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        icycle(12'h301, 8'h71, 4'h2, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        sub(4'h2, 1'b0, 1'b0, 4'd0, 1'b0);
        sub(4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        sub(4'h3, 1'b0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        tests++;
        if (bus.rec_valid !== 1'b0 || bus.locked !== 1'b0 || bus.sync_err !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.drop_count !== '0 || bus.rec_addr !== 12'd0) begin
            fails++;
            $display("FAIL reset_mid: valid=%b locked=%b serr=%b ovf=%b drops=%0d addr=%h, required 0 0 0 0 0 000",
                     bus.rec_valid, bus.locked, bus.sync_err, bus.overflow, bus.drop_count, bus.rec_addr);
        end
        rst = 1'b1;
        bus.rec_ready = 1'b1;
        sub(4'h3, 1'b0, 1'b0, 4'd0, 1'b0);
        sub(4'h0, 1'b1, 1'b0, 4'd0, 1'b0);
        tests++;
        if (bus.locked !== 1'b1 || bus.rec_valid !== 1'b0) begin
            fails++;
            $display("FAIL relock: locked=%b rec_valid=%b, required 1 0", bus.locked, bus.rec_valid);
        end
        icycle(12'h200, 8'h81, 4'hC, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
        drain("reset_mid");
    endtask

    initial begin
        bus.clken_2   = 1'b0;
        bus.sync      = 1'b0;
        bus.cm_rom    = 1'b0;
        bus.cm_ram    = 4'd0;
        bus.dbus_in   = 4'd0;
        bus.enable    = 1'b1;
        bus.rec_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_program();
        test_enable();
        test_io();
        test_sync_err();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
